// File: rtl/mcu_pkg.sv
// Shared types and default SRAM geometry for the MCU memory arbiter.
package mcu_pkg;

    typedef enum logic {
        MST_INSTR = 1'b0,
        MST_DATA  = 1'b1
    } master_e;

    typedef struct packed {
        logic    valid;
        master_e owner;
        logic    err;
    } rsp_t;

    localparam int unsigned SRAM_ADDR_WIDTH = 14;
    localparam logic [31:0] SRAM_BASE_ADDR  = 32'h0000_0000;

endpackage

// File: rtl/mcu_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational, priority flips to the loser on every grant.
module mcu_rr_arb2
    import mcu_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_instr,
    input  logic req_data,
    output logic gnt_instr,
    output logic gnt_data
);

    master_e prio_q;

    always_comb begin
        gnt_instr = req_instr && (!req_data || (prio_q == MST_INSTR));
        gnt_data  = req_data  && (!req_instr || (prio_q == MST_DATA));
    end

    // A lone grant also hands priority to the other master.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= MST_DATA;
        end else if (gnt_instr) begin
            prio_q <= MST_DATA;
        end else if (gnt_data) begin
            prio_q <= MST_INSTR;
        end
    end

endmodule

// File: rtl/mcu_mem_arbiter.sv
// Shares the single-port on-chip SRAM between the core's fetch and data ports,
// with a one-cycle response stage routing rvalid/rdata back to the granted master.
module mcu_mem_arbiter
    import mcu_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter logic [31:0] BASE_ADDR      = SRAM_BASE_ADDR
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      instr_req_i,
    output logic                      instr_gnt_o,
    output logic                      instr_rvalid_o,
    input  logic [31:0]               instr_addr_i,
    output logic [31:0]               instr_rdata_o,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [31:0]               data_addr_i,
    input  logic [31:0]               data_wdata_i,
    output logic [31:0]               data_rdata_o,
    output logic                      data_err_o,
    output logic                      ram_req_o,
    output logic                      ram_we_o,
    output logic [3:0]                ram_be_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]               ram_wdata_o,
    input  logic [31:0]               ram_rdata_i
);

    localparam logic [32:0] RAM_BYTES = 33'd4 << RAM_ADDR_WIDTH;

    logic        gnt_instr;
    logic        gnt_data;
    logic [31:0] sel_offs;
    logic        in_range;
    rsp_t        rsp_d;
    rsp_t        rsp_q;

    mcu_rr_arb2 u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_instr (instr_req_i),
        .req_data  (data_req_i),
        .gnt_instr (gnt_instr),
        .gnt_data  (gnt_data)
    );

    // Range check is only consulted for data; fetches wrap silently into the RAM.
    always_comb begin
        sel_offs = (gnt_instr ? instr_addr_i : data_addr_i) - BASE_ADDR;
        in_range = ({1'b0, sel_offs} < RAM_BYTES);

        ram_req_o   = gnt_instr || (gnt_data && in_range);
        ram_we_o    = gnt_data && data_we_i;
        ram_be_o    = gnt_instr ? 4'hF : data_be_i;
        ram_addr_o  = sel_offs[RAM_ADDR_WIDTH+1:2];
        ram_wdata_o = data_wdata_i;

        rsp_d.valid = gnt_instr || gnt_data;
        rsp_d.owner = gnt_data ? MST_DATA : MST_INSTR;
        rsp_d.err   = gnt_data && !in_range;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_q <= '{valid: 1'b0, owner: MST_INSTR, err: 1'b0};
        end else begin
            rsp_q <= rsp_d;
        end
    end

    assign instr_gnt_o    = gnt_instr;
    assign data_gnt_o     = gnt_data;
    assign instr_rvalid_o = rsp_q.valid && (rsp_q.owner == MST_INSTR);
    assign data_rvalid_o  = rsp_q.valid && (rsp_q.owner == MST_DATA);
    assign data_err_o     = data_rvalid_o && rsp_q.err;
    assign instr_rdata_o  = ram_rdata_i;
    assign data_rdata_o   = rsp_q.err ? 32'h0 : ram_rdata_i;

endmodule

// File: tb/tb_mcu_mem_arbiter.sv
// Directed bench for mcu_mem_arbiter with a behavioural 1-cycle-latency SRAM.
module tb_mcu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        instr_req, instr_gnt, instr_rvalid;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_gnt, data_rvalid, data_we, data_err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        ram_req, ram_we;
    logic [3:0]  ram_be;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    logic [31:0] mem [0:16383];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mcu_mem_arbiter dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_addr_i   (instr_addr),
        .instr_rdata_o  (instr_rdata),
        .data_req_i     (data_req),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_rdata_o   (data_rdata),
        .data_err_o     (data_err),
        .ram_req_o      (ram_req),
        .ram_we_o       (ram_we),
        .ram_be_o       (ram_be),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_rdata_i    (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0; data_be = 4'hF;
        instr_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle();
        rst_ni = 1'b0;
        #1;
        n_checks++; if (instr_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_rvalid got %b exp 0", instr_rvalid); end
        n_checks++; if (data_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_data_rvalid got %b exp 0", data_rvalid); end
        n_checks++; if (data_err !== 1'b0) begin n_fail++; $display("FAIL reset_data_err got %b exp 0", data_err); end
        n_checks++; if ({instr_gnt, data_gnt, ram_req} !== 3'b000) begin n_fail++; $display("FAIL reset_gnt_req got %b exp 000", {instr_gnt, data_gnt, ram_req}); end
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_instr_fetch();
        instr_req = 1'b1; instr_addr = 32'h0000_0100;
        #1;
        n_checks++; if ({instr_gnt, data_gnt, ram_req} !== 3'b101) begin n_fail++; $display("FAIL fetch_gnt got %b exp 101", {instr_gnt, data_gnt, ram_req}); end
        n_checks++; if (ram_addr !== 14'h040) begin n_fail++; $display("FAIL fetch_ram_addr got %h exp 040", ram_addr); end
        n_checks++; if ({ram_we, ram_be} !== 5'b0_1111) begin n_fail++; $display("FAIL fetch_we_be got %b exp 01111", {ram_we, ram_be}); end
        step();
        instr_req = 1'b0;
        #1;
        n_checks++; if ({instr_rvalid, data_rvalid} !== 2'b10) begin n_fail++; $display("FAIL fetch_rvalid got %b exp 10", {instr_rvalid, data_rvalid}); end
        n_checks++; if (instr_rdata !== 32'h0000_0013) begin n_fail++; $display("FAIL fetch_rdata got %h exp 00000013", instr_rdata); end
        step();
    endtask

    task automatic test_conflict();
        logic exp_data;
        logic prev_data;
        do_reset();
        instr_req = 1'b1; instr_addr = 32'h0000_0100;
        data_req = 1'b1; data_addr = 32'h0000_0000; data_we = 1'b0;
        prev_data = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_data = (i % 2 == 0);
            #1;
            n_checks++; if ({data_gnt, instr_gnt} !== {exp_data, ~exp_data}) begin n_fail++; $display("FAIL conflict_gnt[%0d] got d%b i%b exp d%b", i, data_gnt, instr_gnt, exp_data); end
            if (i > 0) begin
                n_checks++; if ({data_rvalid, instr_rvalid} !== {prev_data, ~prev_data}) begin n_fail++; $display("FAIL conflict_rvalid[%0d] got d%b i%b exp d%b", i, data_rvalid, instr_rvalid, prev_data); end
            end
            prev_data = exp_data;
            step();
        end
        idle();
        #1;
        n_checks++; if ({data_rvalid, instr_rvalid} !== 2'b01) begin n_fail++; $display("FAIL conflict_last_rvalid got %b exp 01", {data_rvalid, instr_rvalid}); end
        step();
    endtask

    task automatic test_write_read();
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
        data_addr = 32'h0000_0008; data_wdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if ({data_gnt, ram_req, ram_we, ram_be} !== 7'b111_0011) begin n_fail++; $display("FAIL wr_ctrl got %b exp 1110011", {data_gnt, ram_req, ram_we, ram_be}); end
        n_checks++; if ({ram_addr, ram_wdata} !== {14'h0002, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL wr_addr_data got %h/%h exp 0002/deadbeef", ram_addr, ram_wdata); end
        step();
        data_we = 1'b0; data_be = 4'hF;
        #1;
        n_checks++; if ({data_rvalid, data_err, data_gnt} !== 3'b101) begin n_fail++; $display("FAIL wr_rsp got %b exp 101", {data_rvalid, data_err, data_gnt}); end
        step();
        idle();
        #1;
        n_checks++; if (data_rvalid !== 1'b1 || data_rdata !== 32'h1122_BEEF) begin n_fail++; $display("FAIL rd_after_wr got v%b %h exp v1 1122beef", data_rvalid, data_rdata); end
        step();
    endtask

    task automatic test_out_of_range();
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0001_0000;
        #1;
        n_checks++; if ({data_gnt, ram_req} !== 2'b10) begin n_fail++; $display("FAIL oor_gnt_req got %b exp 10", {data_gnt, ram_req}); end
        step();
        data_addr = 32'h0000_FFFC;
        #1;
        n_checks++; if ({data_rvalid, data_err} !== 2'b11 || data_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_rsp got v%b e%b %h exp v1 e1 0", data_rvalid, data_err, data_rdata); end
        n_checks++; if (ram_req !== 1'b1 || ram_addr !== 14'h3FFF) begin n_fail++; $display("FAIL last_word_req got %b %h exp 1 3fff", ram_req, ram_addr); end
        step();
        data_req = 1'b0;
        instr_req = 1'b1; instr_addr = 32'h0001_0100;
        #1;
        n_checks++; if ({data_rvalid, data_err} !== 2'b10 || data_rdata !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL last_word_rsp got v%b e%b %h exp v1 e0 5a5a5a5a", data_rvalid, data_err, data_rdata); end
        n_checks++; if ({instr_gnt, ram_req} !== 2'b11 || ram_addr !== 14'h040) begin n_fail++; $display("FAIL instr_wrap got %b %h exp 11 040", {instr_gnt, ram_req}, ram_addr); end
        step();
        idle();
        #1;
        n_checks++; if ({instr_rvalid, data_rvalid, data_err} !== 3'b100 || instr_rdata !== 32'h0000_0013) begin n_fail++; $display("FAIL instr_wrap_rsp got %b %h exp 100 00000013", {instr_rvalid, data_rvalid, data_err}, instr_rdata); end
        step();
    endtask

    task automatic test_reset_pending();
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0000;
        #1;
        n_checks++; if (data_gnt !== 1'b1) begin n_fail++; $display("FAIL rstp_gnt got %b exp 1", data_gnt); end
        step();
        rst_ni = 1'b0; idle();
        #1;
        n_checks++; if ({instr_rvalid, data_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rstp_during got %b exp 00", {instr_rvalid, data_rvalid}); end
        step();
        rst_ni = 1'b1;
        step();
        n_checks++; if ({instr_rvalid, data_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rstp_after got %b exp 00", {instr_rvalid, data_rvalid}); end
        instr_req = 1'b1; instr_addr = 32'h0000_0100; data_req = 1'b1;
        #1;
        n_checks++; if ({data_gnt, instr_gnt} !== 2'b10) begin n_fail++; $display("FAIL rstp_prio got d%b i%b exp d1 i0", data_gnt, instr_gnt); end
        step();
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd [0:2];
        exp_rd[0] = 32'hA000_0000; exp_rd[1] = 32'hA111_1111; exp_rd[2] = 32'h1122_BEEF;
        for (int i = 0; i < 4; i++) begin
            data_req = (i < 3); data_we = 1'b0; data_addr = 32'(i * 4);
            #1;
            n_checks++; if (data_gnt !== (i < 3)) begin n_fail++; $display("FAIL b2b_gnt[%0d] got %b", i, data_gnt); end
            if (i > 0) begin
                n_checks++; if (data_rvalid !== 1'b1 || data_rdata !== exp_rd[i-1]) begin n_fail++; $display("FAIL b2b_rsp[%0d] got v%b %h exp v1 %h", i, data_rvalid, data_rdata, exp_rd[i-1]); end
            end
            step();
        end
        idle();
        #1;
        n_checks++; if (data_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b exp 0", data_rvalid); end
    endtask

    initial begin
        mem[14'h0000] = 32'hA000_0000;
        mem[14'h0001] = 32'hA111_1111;
        mem[14'h0002] = 32'h1122_3344;
        mem[14'h0040] = 32'h0000_0013;
        mem[14'h3FFF] = 32'h5A5A_5A5A;
        rst_ni = 1'b1;
        idle();
        #2;
        test_reset();
        test_instr_fetch();
        test_conflict();
        test_write_read();
        test_out_of_range();
        test_reset_pending();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
